// File: rtl/vga_digit_renderer_if.sv
// Pixel, write and colour signals between the VGA timing/control side and the digit renderer.
interface vga_digit_renderer_if #(
  parameter int IDX_W   = 3,
  parameter int COLOR_W = 10
);
  logic [9:0]         iVGA_X, iVGA_Y, iORG_X, iORG_Y;
  logic               iWR_EN;
  logic [IDX_W-1:0]   iWR_IDX;
  logic [3:0]         iWR_VAL;
  logic               iCUR_EN;
  logic [IDX_W-1:0]   iCUR_IDX;
  logic [COLOR_W-1:0] iFG_R, iFG_G, iFG_B;
  logic [COLOR_W-1:0] oRed, oGreen, oBlue;
  logic [3:0]         oVal;

  modport master (
    output iVGA_X, iVGA_Y, iORG_X, iORG_Y, iWR_EN, iWR_IDX, iWR_VAL,
           iCUR_EN, iCUR_IDX, iFG_R, iFG_G, iFG_B,
    input  oRed, oGreen, oBlue, oVal
  );
  modport slave (
    input  iVGA_X, iVGA_Y, iORG_X, iORG_Y, iWR_EN, iWR_IDX, iWR_VAL,
           iCUR_EN, iCUR_IDX, iFG_R, iFG_G, iFG_B,
    output oRed, oGreen, oBlue, oVal
  );
endinterface

// File: rtl/vga_digit_renderer.sv
// Multi-digit hex seven-segment renderer, 2-clock pixel pipeline with blinking cursor.
// Optional macro LEADING_ZERO_BLANK_EN: blank leading zero digits (rightmost digit always shown).
module vga_digit_renderer #(
  parameter int NUM_DIGITS   = 8,
  parameter int IDX_W        = 3,
  parameter int SEG_LEN      = 30,
  parameter int SEG_THICK    = 2,
  parameter int DIGIT_PITCH  = 40,
  parameter int COLOR_W      = 10,
  parameter int BLINK_FRAMES = 30
)(
  input logic                  iVGA_CLK,
  input logic                  iRST_N,
  vga_digit_renderer_if.slave  bus
);
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [9:0] L  = 10'(SEG_LEN);
  localparam logic [9:0] T  = 10'(SEG_THICK);

  function automatic logic [6:0] seg_decode(input logic [3:0] v); // {a,b,c,d,e,f,g}
    case (v)
      4'h0: seg_decode = 7'b1111110;
      4'h1: seg_decode = 7'b0110000;
      4'h2: seg_decode = 7'b1101101;
      4'h3: seg_decode = 7'b1111001;
      4'h4: seg_decode = 7'b0110011;
      4'h5: seg_decode = 7'b1011011;
      4'h6: seg_decode = 7'b1011111;
      4'h7: seg_decode = 7'b1110000;
      4'h8: seg_decode = 7'b1111111;
      4'h9: seg_decode = 7'b1111011;
      4'hA: seg_decode = 7'b1110111;
      4'hB: seg_decode = 7'b0011111;
      4'hC: seg_decode = 7'b1001110;
      4'hD: seg_decode = 7'b0111101;
      4'hE: seg_decode = 7'b1001111;
      default: seg_decode = 7'b1000111;
    endcase
  endfunction

  logic [NUM_DIGITS-1:0][3:0] r_buf;
  logic [3:0]                 r_val;
  logic                       r_in;
  logic [IDX_W-1:0]           r_d;
  logic [9:0]                 r_lx, r_ly;
  logic [COLOR_W-1:0]         r_red, r_green, r_blue;
  logic                       r_fs_d, r_phase;
  logic [CNT_W-1:0]           r_cnt;

  // Stage 1: origin-relative coordinates and digit slot via per-digit window compare.
  logic signed [10:0] w_rx, w_ly;
  logic               w_in;
  logic [IDX_W-1:0]   w_d;
  logic [9:0]         w_lx;
  assign w_rx = $signed({1'b0, bus.iVGA_X}) - $signed({1'b0, bus.iORG_X});
  assign w_ly = $signed({1'b0, bus.iVGA_Y}) - $signed({1'b0, bus.iORG_Y});

  always_comb begin
    w_in = 1'b0;
    w_d  = '0;
    w_lx = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (!w_rx[10] && {1'b0, w_rx[9:0]} >= 11'(k*DIGIT_PITCH)
                    && {1'b0, w_rx[9:0]} <  11'(k*DIGIT_PITCH + SEG_LEN)) begin
        w_in = 1'b1;
        w_d  = IDX_W'(k);
        w_lx = w_rx[9:0] - 10'(k*DIGIT_PITCH);
      end
    end
    if (w_ly[10] || w_ly[9:0] >= 10'(2*SEG_LEN)) w_in = 1'b0;
  end

  logic w_wr_ok;
  always_comb begin
    w_wr_ok = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (bus.iWR_IDX == IDX_W'(k)) w_wr_ok = bus.iWR_EN;
  end

  // Stage 2 reads the buffer combinationally, so a same-edge write is seen one pixel later.
  logic [3:0]            w_nib;
  logic                  w_lz;
  logic [6:0]            w_hit;
  logic                  w_cur_blank, w_lit;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [NUM_DIGITS-1:0] BLANK_RST = {NUM_DIGITS{1'b1}} >> 1;
  logic [NUM_DIGITS-1:0] r_blank, w_blank;
  logic                  r_wr_d, w_seen;
  always_comb begin
    w_blank = '0;
    w_seen  = 1'b0;
    for (int k = 0; k < NUM_DIGITS-1; k++) begin
      if (r_buf[k] != 4'h0) w_seen = 1'b1;
      w_blank[k] = !w_seen;
    end
  end
  always_ff @(posedge iVGA_CLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_wr_d  <= 1'b0;
      r_blank <= BLANK_RST;
    end else begin
      r_wr_d <= w_wr_ok;
      if (r_wr_d) r_blank <= w_blank;
    end
  end
`endif

  always_comb begin
    w_nib = '0;
    w_lz  = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_d == IDX_W'(k)) begin
        w_nib = r_buf[k];
`ifdef LEADING_ZERO_BLANK_EN
        w_lz  = r_blank[k];
`endif
      end
    end
  end

  assign w_hit = { r_ly < T,
                   r_lx >= L - T && r_ly <  L,
                   r_lx >= L - T && r_ly >= L,
                   r_ly >= 10'(2*SEG_LEN - SEG_THICK),
                   r_lx <  T && r_ly >= L,
                   r_lx <  T && r_ly <  L,
                   r_ly >= L && r_ly < L + T };
  assign w_cur_blank = bus.iCUR_EN && !r_phase && (r_d == bus.iCUR_IDX);
  assign w_lit       = r_in && |(seg_decode(w_nib) & w_hit) && !w_cur_blank && !w_lz;

  logic w_fs;
  assign w_fs = (bus.iVGA_X == 10'd0) && (bus.iVGA_Y == 10'd0);

  always_ff @(posedge iVGA_CLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_buf   <= '0;
      r_val   <= '0;
      r_in    <= 1'b0;
      r_d     <= '0;
      r_lx    <= '0;
      r_ly    <= '0;
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
      r_fs_d  <= 1'b0;
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else begin
      for (int k = 0; k < NUM_DIGITS; k++)
        if (bus.iWR_EN && bus.iWR_IDX == IDX_W'(k)) r_buf[k] <= bus.iWR_VAL;
      if (w_wr_ok) r_val <= bus.iWR_VAL;

      r_in <= w_in;
      r_d  <= w_d;
      r_lx <= w_lx;
      r_ly <= w_ly[9:0];

      r_red   <= w_lit ? bus.iFG_R : '0;
      r_green <= w_lit ? bus.iFG_G : '0;
      r_blue  <= w_lit ? bus.iFG_B : '0;

      // Edge-detect so a held (0,0) counts as a single frame start.
      r_fs_d <= w_fs;
      if (w_fs && !r_fs_d) begin
        if (r_cnt == CNT_W'(BLINK_FRAMES-1)) begin
          r_cnt   <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.oRed   = r_red;
  assign bus.oGreen = r_green;
  assign bus.oBlue  = r_blue;
  assign bus.oVal   = r_val;
endmodule

// File: tb/tb_vga_digit_renderer.sv
// Bench for vga_digit_renderer: directed vector table, corner sequences, randomized model compare.
module tb_vga_digit_renderer;
  localparam int N = 8, IW = 4, CW = 10, L = 30, T = 2, P = 40, BF = 2;
  localparam logic [29:0] FG = {10'h3ff, 10'h155, 10'h2aa};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_digit_renderer_if #(.IDX_W(IW), .COLOR_W(CW)) bus();
  vga_digit_renderer #(.NUM_DIGITS(N), .IDX_W(IW), .SEG_LEN(L), .SEG_THICK(T),
                       .DIGIT_PITCH(P), .COLOR_W(CW), .BLINK_FRAMES(BF))
    dut (.iVGA_CLK(clk), .iRST_N(rst_n), .bus(bus));

  int n_chk = 0, n_fail = 0;
  int m_buf[N];
  int m_val = 0, m_fs = 0;
  string GLYPH[16] = '{"abcdef", "bc", "abged", "abgcd", "fgbc", "afgcd", "afgedc", "abc",
                       "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  typedef struct { bit is_wr; int a; int b; bit exp_lit; int exp_val; } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit has(input string s, input byte c);
    for (int i = 0; i < s.len(); i++) if (s[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: rules applied directly to integer pixel coordinates.
  function automatic logic [29:0] model_rgb(input int x, input int y, input int ox, input int oy,
                                            input bit cen, input int cidx);
    int rx, ly, d, lx;
    string g;
    bit lit;
    rx = x - ox; ly = y - oy;
    if (rx < 0 || ly < 0 || ly >= 2*L) return '0;
    d = rx / P; lx = rx % P;
    if (d >= N || lx >= L) return '0;
    if (cen && cidx == d && ((m_fs / BF) % 2 == 1)) return '0;
`ifdef LEADING_ZERO_BLANK_EN
    if (d < N-1) begin
      bit all0 = 1'b1;
      for (int i = 0; i <= d; i++) if (m_buf[i] != 0) all0 = 1'b0;
      if (all0) return '0;
    end
`endif
    g = GLYPH[m_buf[d]];
    lit = (has(g, "a") && ly < T) || (has(g, "g") && ly >= L && ly < L+T) ||
          (has(g, "d") && ly >= 2*L-T) ||
          (has(g, "f") && lx < T && ly < L) || (has(g, "e") && lx < T && ly >= L) ||
          (has(g, "b") && lx >= L-T && ly < L) || (has(g, "c") && lx >= L-T && ly >= L);
    return lit ? FG : '0;
  endfunction

  task automatic set_px(input int x, input int y);
    bus.iVGA_X = 10'(x);
    bus.iVGA_Y = 10'(y);
  endtask

  // All tasks begin and end just after a falling edge.
  task automatic probe(input int x, input int y, output logic [29:0] rgb);
    set_px(x, y);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rgb = {bus.oRed, bus.oGreen, bus.oBlue};
  endtask

  task automatic wr(input int idx, input int val);
    bus.iWR_EN = 1'b1; bus.iWR_IDX = IW'(idx); bus.iWR_VAL = 4'(val);
    @(negedge clk);
    bus.iWR_EN = 1'b0;
    if (idx < N) begin m_buf[idx] = val; m_val = val; end
  endtask

  task automatic frame();
    set_px(0, 0);
    repeat (4) @(negedge clk);
    set_px(3, 3);
    @(negedge clk);
    m_fs++;
  endtask

  task automatic model_reset();
    foreach (m_buf[i]) m_buf[i] = 0;
    m_val = 0; m_fs = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [29:0] rgb;
    model_reset();
    set_px(5, 5);
    bus.iORG_X = 10'd100; bus.iORG_Y = 10'd50;
    bus.iWR_EN = 1'b0; bus.iWR_IDX = '0; bus.iWR_VAL = '0;
    bus.iCUR_EN = 1'b0; bus.iCUR_IDX = '0;
    {bus.iFG_R, bus.iFG_G, bus.iFG_B} = FG;
    repeat (2) @(negedge clk);
    check("reset_rgb", {2'b0, bus.oRed, bus.oGreen, bus.oBlue}, 0);
    check("reset_oval", {28'b0, bus.oVal}, 0);
    rst_n = 1'b1;

    vecs = '{'{1, 0, 1, 0, 1},   '{0, 129, 55, 1, 0},  '{0, 100, 50, 0, 0},
             '{1, 1, 8, 0, 8},   '{0, 145, 109, 1, 0}, '{0, 140, 89, 1, 0},
             '{1, 1, 10, 0, 10}, '{0, 145, 109, 0, 0}, '{0, 140, 50, 1, 0},
             '{0, 140, 89, 1, 0}, '{1, 0, 8, 0, 8},    '{0, 129, 79, 1, 0},
             '{0, 135, 60, 0, 0}, '{0, 99, 60, 0, 0},  '{0, 110, 110, 0, 0},
             '{0, 110, 109, 1, 0}, '{1, 7, 8, 0, 8},   '{0, 380, 55, 1, 0},
             '{0, 409, 55, 1, 0}, '{0, 410, 55, 0, 0}, '{0, 420, 55, 0, 0},
             '{1, 9, 5, 0, 8},   '{1, 8, 3, 0, 8},     '{0, 129, 79, 1, 0},
             '{0, 380, 55, 1, 0}};
    foreach (vecs[i]) begin
      if (vecs[i].is_wr) begin
        wr(vecs[i].a, vecs[i].b);
        check($sformatf("vec%0d_oval", i), {28'b0, bus.oVal}, vecs[i].exp_val);
      end else begin
        probe(vecs[i].a, vecs[i].b, rgb);
        check($sformatf("vec%0d_rgb", i), {2'b0, rgb}, vecs[i].exp_lit ? {2'b0, FG} : 32'd0);
      end
    end

    // Cursor blink on digit 0 with two frames per half-period.
    bus.iCUR_EN = 1'b1; bus.iCUR_IDX = 4'd0;
    wr(0, 7);
    probe(129, 55, rgb); check("blink_visible0", {2'b0, rgb}, {2'b0, FG});
    frame(); frame();
    probe(129, 55, rgb); check("blink_hidden", {2'b0, rgb}, 0);
    probe(140, 50, rgb); check("blink_other_digit", {2'b0, rgb}, {2'b0, FG});
    bus.iCUR_EN = 1'b0;
    probe(129, 55, rgb); check("blink_disabled", {2'b0, rgb}, {2'b0, FG});
    bus.iCUR_EN = 1'b1; bus.iCUR_IDX = 4'd8;
    probe(129, 55, rgb); check("blink_idx_oob", {2'b0, rgb}, {2'b0, FG});
    bus.iCUR_IDX = 4'd0;
    probe(129, 55, rgb); check("blink_hidden2", {2'b0, rgb}, 0);
    frame(); frame();
    probe(129, 55, rgb); check("blink_visible1", {2'b0, rgb}, {2'b0, FG});
    bus.iCUR_EN = 1'b0;

    // Write landing on the same edge the pixel reads digit 0: old glyph first, new one next.
    set_px(129, 55);
    @(posedge clk); @(negedge clk);
    bus.iWR_EN = 1'b1; bus.iWR_IDX = 4'd0; bus.iWR_VAL = 4'd5;
    @(posedge clk); @(negedge clk);
    bus.iWR_EN = 1'b0;
    m_buf[0] = 5; m_val = 5;
    check("wr_same_cycle_old", {2'b0, bus.oRed, bus.oGreen, bus.oBlue}, {2'b0, FG});
    @(posedge clk); @(negedge clk);
    check("wr_same_cycle_new", {2'b0, bus.oRed, bus.oGreen, bus.oBlue}, 0);
    check("wr_same_cycle_oval", {28'b0, bus.oVal}, 5);

    // Randomized pixels, writes and frame starts against the model.
    for (int it = 0; it < 400; it++) begin
      int op = $urandom_range(0, 99);
      if (op < 25) begin
        int idx = $urandom_range(0, 15);
        wr(idx, $urandom_range(0, 15));
        check($sformatf("rand%0d_oval", it), {28'b0, bus.oVal}, m_val);
      end else if (op < 30) begin
        frame();
      end else begin
        int ox = $urandom_range(10, 300), oy = $urandom_range(3, 200);
        int x = ox - 5 + $urandom_range(0, 339), y = oy - 3 + $urandom_range(0, 65);
        bit ce = 1'($urandom_range(0, 1));
        int ci = $urandom_range(0, 15);
        bus.iORG_X = 10'(ox); bus.iORG_Y = 10'(oy);
        bus.iCUR_EN = ce; bus.iCUR_IDX = IW'(ci);
        probe(x, y, rgb);
        check($sformatf("rand%0d_px_%0d_%0d", it, x, y), {2'b0, rgb},
              {2'b0, model_rgb(x, y, ox, oy, ce, ci)});
      end
    end
    bus.iORG_X = 10'd100; bus.iORG_Y = 10'd50; bus.iCUR_EN = 1'b0;

    // Asynchronous reset in the middle of a lit run of pixels.
    wr(0, 8);
    probe(115, 81, rgb); check("pre_reset_g", {2'b0, rgb}, {2'b0, FG});
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_rgb", {2'b0, bus.oRed, bus.oGreen, bus.oBlue}, 0);
    check("async_reset_oval", {28'b0, bus.oVal}, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    probe(115, 81, rgb); check("post_reset_g", {2'b0, rgb}, 0);
    probe(129, 55, rgb);
`ifdef LEADING_ZERO_BLANK_EN
    check("post_reset_d0", {2'b0, rgb}, 0);
`else
    check("post_reset_d0", {2'b0, rgb}, {2'b0, FG});
`endif

    // Leading zeros in front of a 3; rightmost digit shows even when zero.
    wr(0, 0); wr(1, 0); wr(2, 3);
    probe(209, 55, rgb); check("lz_digit2", {2'b0, rgb}, {2'b0, FG});
    probe(409, 55, rgb); check("lz_rightmost", {2'b0, rgb}, {2'b0, FG});
    probe(169, 55, rgb);
`ifdef LEADING_ZERO_BLANK_EN
    check("lz_digit1", {2'b0, rgb}, 0);
`else
    check("lz_digit1", {2'b0, rgb}, {2'b0, FG});
`endif
    probe(129, 55, rgb);
    check("lz_digit0_model", {2'b0, rgb}, {2'b0, model_rgb(129, 55, 100, 50, 1'b0, 0)});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
